led_ctrl: RTL
=============

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter N_LEDS, default 3: number of LED channels, range 1..16.
REQ-002 SHALL have parameter BLINK_W, default 25: width of the free-running timebase; must exceed PWM_W.
REQ-003 SHALL have parameter PWM_W, default 8: PWM duty resolution in bits.
REQ-004 SHALL have parameter RESET_MODE, default 2'b10: mode loaded into every channel at reset.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: when 1, leds outputs are inverted (0 = lit).
REQ-006 SHALL have port input_clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port input_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-009 SHALL have port cfg_sel, input, 4 bits: target channel index.
REQ-010 SHALL have port cfg_mode, input, 2 bits: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
REQ-011 SHALL have port cfg_duty, input, PWM_W bits: PWM duty value.
REQ-012 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected write.
REQ-013 SHALL have port leds, output, N_LEDS bits: registered LED drive.

Function
REQ-014 SHALL keep a BLINK_W-bit counter tb that increments by 1 every cycle and wraps from all-ones to 0 with no stall.
REQ-015 SHALL derive blink_phase = tb[BLINK_W-1] and pwm_ctr = tb[PWM_W-1:0].
REQ-016 SHALL hold mode[i] (2 bits) and duty[i] (PWM_W bits) registers for each channel.
REQ-017 SHALL, when cfg_we=1 and cfg_sel<N_LEDS at a rising edge, load mode[cfg_sel]=cfg_mode and duty[cfg_sel]=cfg_duty; other channels unchanged.
REQ-018 SHALL, when cfg_we=1 and cfg_sel>=N_LEDS, change no register and assert cfg_err for exactly the next cycle.
REQ-019 SHALL otherwise hold cfg_err=0; back-to-back invalid writes give cfg_err high on each following cycle.
REQ-020 SHALL compute lit[i]: OFF gives 0; ON gives 1; BLINK gives blink_phase; PWM gives (pwm_ctr < duty[i]), an unsigned compare.
REQ-021 SHALL treat PWM duty=0 as never lit and duty=2^PWM_W-1 as lit for all but one cycle per PWM period.
REQ-022 SHALL register leds[i] = lit[i] XOR ACTIVE_LOW, with lit sampled from the current tb and mode/duty registers.
REQ-023 SHALL make a write sampled at edge k visible on leds at edge k+1, i.e. the second edge counted from the strobe.
REQ-024 SHALL give all channels in the same mode and duty identical, phase-aligned outputs, since they share tb.
REQ-025 SHALL make a write to a channel affect that channel only; repeated writes are last-wins per edge.
REQ-026 SHALL continue counting tb uninterrupted across configuration writes.

Reset
REQ-027 SHALL, while input_rst=1 and independent of input_clk, force tb=0, mode[i]=RESET_MODE, duty[i]=0, cfg_err=0 and leds={N_LEDS{ACTIVE_LOW}} (all unlit).
REQ-028 SHALL ignore cfg_we while reset is asserted.
REQ-029 SHALL resume counting on the first rising edge after reset deasserts, with tb=1 after that edge.
REQ-030 SHALL, on reset asserted mid-operation, drop any in-flight write and restore all REQ-027 values immediately.

Verification (bench uses BLINK_W=4, PWM_W=2, N_LEDS=3, ACTIVE_LOW=1, RESET_MODE=10)
REQ-031 SHALL cover reset: assert input_rst asynchronously mid-cycle -> leds=3'b111 and cfg_err=0 immediately; after release, BLINK channels go low (lit) when tb[3]=1, i.e. 8 cycles lit and 8 unlit per 16-cycle period.
REQ-032 SHALL cover PWM: write sel=1, mode=11, duty=2 -> leds[1] low on 2 of every 4 cycles (pwm_ctr 0,1); duty=0 -> leds[1] stays 1; duty=3 -> low 3 of 4 cycles.
REQ-033 SHALL cover an invalid write: cfg_we with sel=5 -> cfg_err=1 for exactly one cycle, all modes unchanged; sel=2 on the next cycle -> cfg_err=0 and the write applied.
REQ-034 SHALL cover latency: write sel=0, mode=01 at edge k -> leds[0]=0 from edge k+1; write mode=00 -> leds[0]=1 at the following k+1.
REQ-035 SHALL cover timebase wrap: run 40 cycles in BLINK -> tb wraps 15 to 0 without a glitch, and the period stays exactly 16 cycles across the wrap.
REQ-036 SHALL cover reset mid-write: input_rst asserted in the same cycle as a cfg_we to sel=0 -> the write is discarded and mode[0] returns to 10 after release.

Source files
------------

// File: rtl/led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_ctrl
//  Purpose  : Multi-channel LED driver. Each channel is OFF, ON, BLINK or
//             PWM. All channels share one free-running timebase, so channels
//             with the same mode and duty produce identical, phase-aligned
//             outputs.
//  Ports    : input_clk  - clock, rising edge
//             input_rst  - asynchronous active-high reset
//             cfg_we     - configuration write strobe
//             cfg_sel    - target channel index (4 bits)
//             cfg_mode   - 00 OFF, 01 ON, 10 BLINK, 11 PWM
//             cfg_duty   - PWM duty value (PWM_W bits)
//             cfg_err    - one-cycle pulse after a write to a missing channel
//             leds       - registered LED drive (polarity set by ACTIVE_LOW)
//  Revision : 1.0  initial release
// ============================================================================
module led_ctrl #(
    parameter int         N_LEDS     = 3,
    parameter int         BLINK_W    = 25,
    parameter int         PWM_W      = 8,
    parameter logic [1:0] RESET_MODE = 2'b10,
    parameter int         ACTIVE_LOW = 1
) (
    input  logic              input_clk,
    input  logic              input_rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_sel,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [N_LEDS-1:0] leds
);

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;

    // Channel count widened to 5 bits so N_LEDS = 16 is representable.
    localparam logic [4:0] c_N_LEDS = 5'(N_LEDS);
    localparam logic       c_POL    = (ACTIVE_LOW != 0);

    logic [BLINK_W-1:0] r_tb;
    logic [1:0]         r_mode [N_LEDS];
    logic [PWM_W-1:0]   r_duty [N_LEDS];
    logic               r_cfg_err;
    logic [N_LEDS-1:0]  r_leds;

    logic               w_sel_ok;
    logic               w_blink_phase;
    logic [PWM_W-1:0]   w_pwm_ctr;
    logic [N_LEDS-1:0]  w_lit;

    assign w_sel_ok      = ({1'b0, cfg_sel} < c_N_LEDS);
    assign w_blink_phase = r_tb[BLINK_W-1];
    assign w_pwm_ctr     = r_tb[PWM_W-1:0];

    // Per-channel lit decode. PWM uses an unsigned strict compare, so
    // duty = 0 never lights and full-scale duty misses one cycle per period.
    generate
        for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
            assign w_lit[i] = (r_mode[i] == c_MODE_OFF)   ? 1'b0 :
                              (r_mode[i] == c_MODE_ON)    ? 1'b1 :
                              (r_mode[i] == c_MODE_BLINK) ? w_blink_phase :
                                                            (w_pwm_ctr < r_duty[i]);
        end
    endgenerate

    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            r_tb      <= '0;
            r_cfg_err <= 1'b0;
            r_leds    <= {N_LEDS{c_POL}};
            for (int i = 0; i < N_LEDS; i++) begin
                r_mode[i] <= RESET_MODE;
                r_duty[i] <= '0;
            end
        end else begin
            // Free-running; natural wrap from all-ones to zero.
            r_tb      <= r_tb + 1'b1;
            r_cfg_err <= cfg_we & ~w_sel_ok;
            // Output reflects the mode/duty held before this edge, so a write
            // becomes visible one edge after it is sampled.
            r_leds    <= w_lit ^ {N_LEDS{c_POL}};
            for (int i = 0; i < N_LEDS; i++) begin
                if (cfg_we && (cfg_sel == 4'(i))) begin
                    r_mode[i] <= cfg_mode;
                    r_duty[i] <= cfg_duty;
                end
            end
        end
    end

    assign cfg_err = r_cfg_err;
    assign leds    = r_leds;

endmodule
`default_nettype wire
